// File: rtl/idli_sqi_mem_m.sv
// Nibble-wide SQI SRAM responder: decodes command/address/dummy/data beats and serves an internal byte array.
// Optional mode-register commands (WRMR 0x01, RDMR 0x05) are enabled by defining IDLI_SQI_MEM_MODE_EN.
module idli_sqi_mem_m #(
  parameter int AW        = 8,
  parameter int DUMMY_NIB = 2
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
`ifdef IDLI_SQI_MEM_MODE_EN
    ST_WRMR,
    ST_RDMR,
`endif
    ST_IGNORE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      cmd_hi, cmd_hi_nx;
  logic [AW-1:0]   addr, addr_nx;
  logic            is_wr, is_wr_nx;
  logic            sel, sel_nx;
  logic [3:0]      pend, pend_nx;
  logic            mem_we;
  logic [1:0]      adv_mode;
  logic [7:0]      rd_byte;
  logic [7:0]      mem [2**AW];

`ifdef IDLI_SQI_MEM_MODE_EN
  logic [7:0]      mode, mode_nx;
  assign adv_mode = mode[7:6];
`else
  assign adv_mode = 2'b01;
`endif

  // 00 holds the address, 10 wraps inside a 32-byte page, anything else is sequential.
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input logic [1:0] m);
    logic [AW-1:0] inc;
    logic [AW-1:0] pm;
    inc = a + 1'b1;
    pm  = AW'(31);
    case (m)
      2'b00:   adv = a;
      2'b10:   adv = (a & ~pm) | (inc & pm);
      default: adv = inc;
    endcase
  endfunction

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state  <= ST_CMD;
      cnt    <= '0;
      cmd_hi <= '0;
      addr   <= '0;
      is_wr  <= 1'b0;
      sel    <= 1'b0;
      pend   <= '0;
`ifdef IDLI_SQI_MEM_MODE_EN
      mode   <= 8'h40;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      cmd_hi <= cmd_hi_nx;
      addr   <= addr_nx;
      is_wr  <= is_wr_nx;
      sel    <= sel_nx;
      pend   <= pend_nx;
`ifdef IDLI_SQI_MEM_MODE_EN
      mode   <= mode_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    cmd_hi_nx = cmd_hi;
    addr_nx   = addr;
    is_wr_nx  = is_wr;
    sel_nx    = sel;
    pend_nx   = pend;
    mem_we    = 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
    mode_nx   = mode;
`endif
    if (i_mem_cs) begin
      state_nx = ST_CMD;
      cnt_nx   = '0;
      sel_nx   = 1'b0;
      pend_nx  = '0;
    end else if (i_mem_sck) begin
      case (state)
        ST_CMD: begin
          if (cnt == '0) begin
            cmd_hi_nx = i_mem_sio;
            cnt_nx    = CW'(1);
          end else begin
            cnt_nx = '0;
            sel_nx = 1'b0;
            case ({cmd_hi, i_mem_sio})
              8'h03: begin state_nx = ST_ADDR; is_wr_nx = 1'b0; end
              8'h02: begin state_nx = ST_ADDR; is_wr_nx = 1'b1; end
`ifdef IDLI_SQI_MEM_MODE_EN
              8'h01: state_nx = ST_WRMR;
              8'h05: state_nx = ST_RDMR;
`endif
              default: state_nx = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          // Shifting all 24 address bits through leaves only the low AW bits.
          addr_nx = AW'({addr, i_mem_sio});
          if (cnt == CW'(5)) begin
            cnt_nx = '0;
            sel_nx = 1'b0;
            if (is_wr)               state_nx = ST_WR_DATA;
            else if (DUMMY_NIB == 0) state_nx = ST_RD_DATA;
            else                     state_nx = ST_DUMMY;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_DUMMY: begin
          if (cnt == CW'(DUMMY_NIB - 1)) begin
            cnt_nx   = '0;
            state_nx = ST_RD_DATA;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_RD_DATA: begin
          sel_nx = ~sel;
          if (sel) addr_nx = adv(addr, adv_mode);
        end
        ST_WR_DATA: begin
          if (!sel) begin
            pend_nx = i_mem_sio;
            sel_nx  = 1'b1;
          end else begin
            mem_we  = 1'b1;
            addr_nx = adv(addr, adv_mode);
            sel_nx  = 1'b0;
          end
        end
`ifdef IDLI_SQI_MEM_MODE_EN
        ST_WRMR: begin
          if (cnt == '0) begin
            cmd_hi_nx = i_mem_sio;
            cnt_nx    = CW'(1);
          end else begin
            mode_nx  = {cmd_hi, i_mem_sio};
            cnt_nx   = '0;
            state_nx = ST_IGNORE;
          end
        end
        ST_RDMR: sel_nx = ~sel;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_mem_gck) begin
    if (mem_we) mem[addr] <= {pend, i_mem_sio};
  end

  // Read data is decoded from registered state so it is valid for the whole beat cycle.
  always_comb begin
    o_mem_sio    = 4'h0;
    o_mem_sio_oe = 1'b0;
    rd_byte      = mem[addr];
    case (state)
      ST_RD_DATA: begin
        o_mem_sio_oe = 1'b1;
        o_mem_sio    = sel ? rd_byte[3:0] : rd_byte[7:4];
      end
`ifdef IDLI_SQI_MEM_MODE_EN
      ST_RDMR: begin
        o_mem_sio_oe = 1'b1;
        o_mem_sio    = sel ? mode[3:0] : mode[7:4];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: write/read, wrap, aborted write, unknown command, reset, stalls.
// Mode-register steps run when IDLI_SQI_MEM_MODE_EN is defined.
module tb_idli_sqi_mem_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out;
  logic       oe;

  int         checks = 0;
  int         errors = 0;
  int         gap = 0;
  logic [3:0] cap_sio;
  logic       cap_oe;
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];

  idli_sqi_mem_m #(.AW(8), .DUMMY_NIB(2)) dut (
    .i_mem_gck   (clk),
    .i_mem_rst_n (rst_n),
    .i_mem_sck   (sck),
    .i_mem_cs    (cs),
    .i_mem_sio   (sio_in),
    .o_mem_sio   (sio_out),
    .o_mem_sio_oe(oe)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: outputs are captured at the falling edge, before the new inputs are applied.
  task automatic drive(input logic c, input logic s, input logic [3:0] n);
    @(negedge clk);
    cap_sio = sio_out;
    cap_oe  = oe;
    cs      = c;
    sck     = s;
    sio_in  = n;
  endtask

  task automatic send_nib(input logic [3:0] n);
    repeat (gap) drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b1, n);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic end_tx();
    drive(1'b1, 1'b0, 4'h0);
  endtask

  task automatic write_tx(input logic [23:0] a);
    send_byte(8'h02);
    send_addr(a);
    while (wr_q.size() > 0) send_byte(wr_q.pop_front());
    end_tx();
  endtask

  // Scoreboard: each expected byte is checked as two driven nibbles.
  task automatic read_tx(input logic [23:0] a);
    logic [7:0] e;
    send_byte(8'h03);
    send_addr(a);
    for (int i = 0; i < 2; i++) begin
      send_nib(4'h0);
      check("dummy_oe", {7'd0, cap_oe}, 8'd0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      send_nib(4'h0);
      check("rd_oe_hi", {7'd0, cap_oe}, 8'd1);
      check("rd_hi", {4'd0, cap_sio}, {4'd0, e[7:4]});
      send_nib(4'h0);
      check("rd_oe_lo", {7'd0, cap_oe}, 8'd1);
      check("rd_lo", {4'd0, cap_sio}, {4'd0, e[3:0]});
    end
    end_tx();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_oe", {7'd0, oe}, 8'd0);
    check("rst_sio", {4'd0, sio_out}, 8'd0);
    rst_n = 1'b1;
    end_tx();

    // Basic write then read
    wr_q = '{8'hA5, 8'h3C};
    write_tx(24'h000010);
    exp_q = '{8'hA5, 8'h3C};
    read_tx(24'h000010);

    // Sequential wrap at the top of the array; upper address bits ignored
    wr_q = '{8'h11, 8'h22};
    write_tx(24'h0000FF);
    exp_q = '{8'h22};
    read_tx(24'h000000);
    exp_q = '{8'h11, 8'h22};
    read_tx(24'h0100FF);

    // Aborted half-byte write leaves the next byte untouched
    wr_q = '{8'h00, 8'h96};
    write_tx(24'h000020);
    send_byte(8'h02);
    send_addr(24'h000020);
    send_nib(4'h7);
    send_nib(4'h7);
    send_nib(4'h8);
    end_tx();
    exp_q = '{8'h77, 8'h96};
    read_tx(24'h000020);

    // Unknown command absorbs beats without driving or writing
    send_byte(8'hFF);
    for (int i = 0; i < 20; i++) begin
      send_nib(4'h0);
      if (i > 0) check("ign_oe", {7'd0, cap_oe}, 8'd0);
    end
    end_tx();
    exp_q = '{8'h22};
    read_tx(24'h000000);
    exp_q = '{8'hA5};
    read_tx(24'h000010);

    // Reset during read data
    send_byte(8'h03);
    send_addr(24'h000010);
    send_nib(4'h0);
    send_nib(4'h0);
    send_nib(4'h0);
    check("pre_rst_hi", {4'd0, cap_sio}, 8'h0A);
    @(posedge clk);
    #2;
    check("pre_rst_oe", {7'd0, oe}, 8'd1);
    check("pre_rst_lo", {4'd0, sio_out}, 8'h05);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", {7'd0, oe}, 8'd0);
    check("mid_rst_sio", {4'd0, sio_out}, 8'd0);
    end_tx();
    rst_n = 1'b1;
    exp_q = '{8'hA5, 8'h3C};
    read_tx(24'h000010);

    // Stalled beats give the same results
    gap = 3;
    exp_q = '{8'hA5, 8'h3C};
    read_tx(24'h000010);
    wr_q = '{8'h6E};
    write_tx(24'h000050);
    gap = 0;
    exp_q = '{8'h6E};
    read_tx(24'h000050);

`ifdef IDLI_SQI_MEM_MODE_EN
    // Mode register: reset value, byte mode, page mode
    send_byte(8'h05);
    send_nib(4'h0);
    check("rdmr0_oe", {7'd0, cap_oe}, 8'd1);
    check("rdmr0_hi", {4'd0, cap_sio}, 8'h04);
    send_nib(4'h0);
    check("rdmr0_lo", {4'd0, cap_sio}, 8'h00);
    end_tx();
    wr_q = '{8'h5A};
    write_tx(24'h000030);
    send_byte(8'h01);
    send_byte(8'h00);
    end_tx();
    exp_q = '{8'h5A, 8'h5A, 8'h5A};
    read_tx(24'h000030);
    send_byte(8'h05);
    send_nib(4'h0);
    check("rdmr1_oe", {7'd0, cap_oe}, 8'd1);
    check("rdmr1_hi", {4'd0, cap_sio}, 8'h00);
    send_nib(4'h0);
    check("rdmr1_lo", {4'd0, cap_sio}, 8'h00);
    end_tx();
    send_byte(8'h01);
    send_byte(8'h80);
    end_tx();
    wr_q = '{8'hC1, 8'hD2};
    write_tx(24'h00003F);
    send_byte(8'h01);
    send_byte(8'h40);
    end_tx();
    exp_q = '{8'hD2};
    read_tx(24'h000020);
    exp_q = '{8'hC1};
    read_tx(24'h00003F);
`else
    // Mode commands are not decoded: no drive, sequential advance kept
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) begin
      send_nib(4'h0);
      check("rdmr_oe", {7'd0, cap_oe}, 8'd0);
    end
    end_tx();
    send_byte(8'h01);
    send_byte(8'h00);
    end_tx();
    exp_q = '{8'hA5, 8'h3C};
    read_tx(24'h000010);
`endif

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
